// File: rtl/poly_stereo_mixer.sv
// rtl/poly_stereo_mixer.sv - frame-paced multi-voice stereo mixer with saturation
// Optional centre attenuation: define MIXER_CENTRE_ATTEN_EN.
module poly_stereo_mixer #(
    parameter int NUM_VOICES = 3,
    parameter int WIDTH      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          new_frame,
    input  logic                          stereo_on,
    input  logic                          samples_ready,
    input  logic [NUM_VOICES*WIDTH-1:0]   voice_samples,
    input  logic [NUM_VOICES*2-1:0]       voice_stereo,
    output logic                          generate_next_sample,
    output logic [WIDTH-1:0]              sample_left,
    output logic [WIDTH-1:0]              sample_right,
    output logic                          clip,
    output logic                          underrun
);

    localparam int ACC_W = WIDTH + 5;
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'((64'd1 << (WIDTH - 1)) - 64'd1);
    localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCUM, S_SAT} state_t;

    state_t                         r_state;
    state_t                         w_next;
    logic                           r_nf_d;
    logic                           r_staged_valid;
    logic [WIDTH-1:0]               r_staged_l;
    logic [WIDTH-1:0]               r_staged_r;
    logic [WIDTH-1:0]               r_out_l;
    logic [WIDTH-1:0]               r_out_r;
    logic                           r_gen;
    logic                           r_clip;
    logic                           r_under;
    logic [NUM_VOICES*WIDTH-1:0]    r_samples;
    logic [NUM_VOICES*2-1:0]        r_routes;
    logic signed [ACC_W-1:0]        r_acc_l;
    logic signed [ACC_W-1:0]        r_acc_r;
    logic [IDX_W-1:0]               r_idx;

    logic                           w_frame;
    logic                           w_capture;
    logic                           w_add;
    logic                           w_sat;
    logic                           w_last;
    logic [WIDTH-1:0]               w_voice;
    logic [1:0]                     w_route;
    logic signed [ACC_W-1:0]        w_ext;
    logic signed [ACC_W-1:0]        w_addend;
    logic                           w_to_l;
    logic                           w_to_r;
    logic                           w_l_hi;
    logic                           w_l_lo;
    logic                           w_r_hi;
    logic                           w_r_lo;
    logic [WIDTH-1:0]               w_sat_l;
    logic [WIDTH-1:0]               w_sat_r;

    assign w_frame = new_frame & ~r_nf_d;
    assign w_last  = (r_idx == IDX_W'(NUM_VOICES - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: a frame event always wins and restarts the request cycle
    always_comb begin
        w_next = r_state;
        if (w_frame) begin
            w_next = S_WAIT;
        end else begin
            case (r_state)
                S_IDLE:  w_next = S_IDLE;
                S_WAIT:  if (samples_ready) w_next = S_ACCUM;
                S_ACCUM: if (w_last) w_next = S_SAT;
                S_SAT:   w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        w_capture = 1'b0;
        w_add     = 1'b0;
        w_sat     = 1'b0;
        if (!w_frame) begin
            w_capture = (r_state == S_WAIT) && samples_ready;
            w_add     = (r_state == S_ACCUM);
            w_sat     = (r_state == S_SAT);
        end
    end

    assign w_voice = r_samples[int'(r_idx)*WIDTH +: WIDTH];
    assign w_route = r_routes[int'(r_idx)*2 +: 2];
    assign w_ext   = {{(ACC_W - WIDTH){w_voice[WIDTH-1]}}, w_voice};

`ifdef MIXER_CENTRE_ATTEN_EN
    assign w_addend = (w_route == 2'b00) ? (w_ext >>> 1) : w_ext;
`else
    assign w_addend = w_ext;
`endif

    // Mono mode collapses left/right-only routes onto both channels; mute always wins
    assign w_to_l = (w_route != 2'b11) && (!stereo_on || (w_route != 2'b10));
    assign w_to_r = (w_route != 2'b11) && (!stereo_on || (w_route != 2'b01));

    assign w_l_hi  = (r_acc_l > ACC_MAX);
    assign w_l_lo  = (r_acc_l < ACC_MIN);
    assign w_r_hi  = (r_acc_r > ACC_MAX);
    assign w_r_lo  = (r_acc_r < ACC_MIN);
    assign w_sat_l = w_l_hi ? ACC_MAX[WIDTH-1:0] : (w_l_lo ? ACC_MIN[WIDTH-1:0] : r_acc_l[WIDTH-1:0]);
    assign w_sat_r = w_r_hi ? ACC_MAX[WIDTH-1:0] : (w_r_lo ? ACC_MIN[WIDTH-1:0] : r_acc_r[WIDTH-1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_samples <= '0;
            r_routes  <= '0;
            r_acc_l   <= '0;
            r_acc_r   <= '0;
            r_idx     <= '0;
        end else if (w_capture) begin
            r_samples <= voice_samples;
            r_routes  <= voice_stereo;
            r_acc_l   <= '0;
            r_acc_r   <= '0;
            r_idx     <= '0;
        end else if (w_add) begin
            if (w_to_l) r_acc_l <= r_acc_l + w_addend;
            if (w_to_r) r_acc_r <= r_acc_r + w_addend;
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nf_d         <= 1'b0;
            r_staged_valid <= 1'b0;
            r_staged_l     <= '0;
            r_staged_r     <= '0;
            r_out_l        <= '0;
            r_out_r        <= '0;
            r_gen          <= 1'b0;
            r_clip         <= 1'b0;
            r_under        <= 1'b0;
        end else begin
            r_nf_d  <= new_frame;
            r_gen   <= w_frame;
            r_under <= w_frame && !r_staged_valid;
            r_clip  <= w_sat && (w_l_hi || w_l_lo || w_r_hi || w_r_lo);
            if (w_frame) begin
                r_staged_valid <= 1'b0;
                if (r_staged_valid) begin
                    r_out_l <= r_staged_l;
                    r_out_r <= r_staged_r;
                end
            end else if (w_sat) begin
                r_staged_valid <= 1'b1;
                r_staged_l     <= w_sat_l;
                r_staged_r     <= w_sat_r;
            end
        end
    end

    assign generate_next_sample = r_gen;
    assign sample_left          = r_out_l;
    assign sample_right         = r_out_r;
    assign clip                 = r_clip;
    assign underrun             = r_under;

endmodule

// File: doc/poly_stereo_mixer.md
POLY_STEREO_MIXER -- requirements
Module: poly_stereo_mixer

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 3, number of mixed voices, legal range 1..16.
REQ-002 SHALL have parameter WIDTH, default 16, two's-complement sample width.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state.
REQ-005 new_frame  input  1  raw codec frame strobe, may stay high several cycles.
REQ-006 stereo_on  input  1  1 = honour per-voice routing, 0 = mono mix.
REQ-007 samples_ready  input  1  one-cycle pulse: all voice_samples valid for the current request.
REQ-008 voice_samples  input  NUM_VOICES*WIDTH  voice i at bits [i*WIDTH +: WIDTH].
REQ-009 voice_stereo  input  NUM_VOICES*2  voice i routing at [2i+:2]: 00 centre, 01 left, 10 right, 11 mute.
REQ-010 generate_next_sample  output  1  one-cycle request to the voice players for the next sample.
REQ-011 sample_left, sample_right  output  WIDTH each  published samples, change only on a frame edge.
REQ-012 clip  output  1  one-cycle pulse when the staged mix saturated.
REQ-013 underrun  output  1  one-cycle pulse when a frame edge found no staged mix.

Function
REQ-014 SHALL detect the new_frame rising edge against a registered copy of new_frame; one edge = one frame event.
REQ-015 On a frame event with staged_valid=1, SHALL load sample_left/right from the staged registers in the same cycle and clear staged_valid.
REQ-016 On a frame event with staged_valid=0, SHALL hold sample_left/right and pulse underrun.
REQ-017 Every frame event SHALL pulse generate_next_sample in the same cycle and move the FSM to WAIT.
REQ-018 FSM states: IDLE, WAIT, ACCUM, SAT.
REQ-019 WAIT: on samples_ready, SHALL capture all voice_samples and voice_stereo, clear both accumulators, set index 0, go to ACCUM.
REQ-020 ACCUM: SHALL add one voice per cycle, index 0..NUM_VOICES-1, sign-extended into accumulators of WIDTH+5 bits; go to SAT after the last voice.
REQ-021 Routing with stereo_on=1: 00 to both, 01 left only, 10 right only, 11 neither.
REQ-022 Routing with stereo_on=0: 00/01/10 to both channels, 11 neither; stereo_on is sampled per voice during ACCUM.
REQ-023 SAT: SHALL clamp each accumulator to [-2^(WIDTH-1), 2^(WIDTH-1)-1], write the staged registers, set staged_valid, pulse clip if either channel clamped, go to IDLE.
REQ-024 Latency from samples_ready to staged_valid SHALL be NUM_VOICES+1 cycles.
REQ-025 samples_ready in IDLE, ACCUM or SAT SHALL be ignored.
REQ-026 A frame event during WAIT, ACCUM or SAT SHALL abandon the mix in progress, pulse underrun, and re-enter WAIT.
REQ-027 A frame event and samples_ready in the same WAIT cycle SHALL resolve as a frame event; samples_ready is dropped.

Reset
REQ-028 Reset SHALL force: FSM to IDLE; sample_left, sample_right, staged registers and accumulators to 0; staged_valid, generate_next_sample, clip and underrun to 0; the registered new_frame to 0.
REQ-029 Reset asserted mid-ACCUM SHALL discard the partial mix; no output changes after release until the next frame event.
REQ-030 A new_frame already high at reset release SHALL count as a frame event on the first clock.

Configuration
REQ-031 Macro MIXER_CENTRE_ATTEN_EN defined: centre-routed (00) voices SHALL be added at half amplitude (arithmetic shift right by 1) to each channel; left/right-only voices stay at full amplitude.
REQ-032 Macro MIXER_CENTRE_ATTEN_EN undefined: all routed voices SHALL be added at full amplitude.

Verification (NUM_VOICES=3, WIDTH=16)
REQ-033 Routing: stereo_on=1, samples 1000(01), 2000(10), 300(00), then frame edge -> left=1300, right=2300 (with macro: 1150/2150), clip=0.
REQ-034 Saturation: three voices of 20000, all 00 -> both outputs 32767, clip pulses once; three voices of -20000 -> both outputs -32768.
REQ-035 Mono/mute: stereo_on=0, samples 100(01), 200(10), 400(11) -> both outputs 300.
REQ-036 Underrun: frame edge with samples_ready withheld -> outputs keep their previous values, underrun pulses, generate_next_sample pulses.
REQ-037 Edge detection: new_frame held high 10 cycles -> exactly one generate_next_sample pulse.
REQ-038 Reset: reset asserted during ACCUM -> all outputs 0 within the same cycle (asynchronous); after release, the first frame edge gives underrun=1 and outputs 0.
